timer_bank: RTL and testbench
=============================

TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 Parameter WIDTH, default 16, data and counter width in bits.
REQ-002 Parameter CHANNELS, default 4, number of independent countdown channels (1..8).
REQ-003 Parameter PRESCALE, default 1, clocks per count tick (1..256).
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 DATA  inout  WIDTH  shared CPU bus; driven only while timer_out=1 and timer_in=0, else high-Z.
REQ-007 timer_in  input  1  load selected channel count and reload from DATA.
REQ-008 ctrl_in  input  1  write selected channel control from DATA[1:0] (bit0 EN, bit1 AR).
REQ-009 timer_out  input  1  drive selected channel count onto DATA.
REQ-010 ack  input  1  clear timeout flag of selected channel.
REQ-011 ch_select  input  max(1,clog2(CHANNELS))  channel index for timer_in/ctrl_in/timer_out/ack.
REQ-012 timeout  output  CHANNELS  per-channel sticky timeout flags.
REQ-013 irq  output  1  OR of all timeout bits.
REQ-014 REG_OUT_TIMER  output  WIDTH  debug: count of selected channel, combinational.

Function
REQ-015 Each channel SHALL hold CNT[WIDTH], RLD[WIDTH], EN, AR and TO registers.
REQ-016 Prescaler SHALL count 0..PRESCALE-1, wrap to 0, and assert internal tick for one clock when at PRESCALE-1; PRESCALE=1 SHALL give a tick every clock.
REQ-017 timer_in SHALL set CNT and RLD of the selected channel to DATA; TO SHALL become 1 if DATA==0, else 0.
REQ-018 ctrl_in SHALL set EN=DATA[0], AR=DATA[1] of the selected channel; CNT, RLD, TO unchanged.
REQ-019 On tick, a channel with EN=1 and CNT>1 SHALL decrement CNT by 1.
REQ-020 On tick, a channel with EN=1 and CNT==1 SHALL set TO=1 and load CNT=RLD if AR=1, else CNT=0.
REQ-021 A channel with CNT==0 SHALL not decrement (no wrap to all-ones) and SHALL not re-set TO.
REQ-022 TO SHALL be sticky; cleared only by ack on that channel, by timer_in with nonzero DATA, or by reset.
REQ-023 Selected-channel priority in one cycle: timer_in over tick; TO set by tick over ack; ctrl_in and timer_in together both apply.
REQ-024 Unselected channels SHALL continue counting independently during any access.
REQ-025 timer_in and timer_out together: load SHALL occur and DATA SHALL not be driven.
REQ-026 timeout SHALL equal the TO vector directly; irq SHALL be combinational OR of TO.
REQ-027 ch_select >= CHANNELS SHALL make all accesses no-ops and REG_OUT_TIMER/DATA read 0.
REQ-028 Prescaler SHALL free-run regardless of EN and accesses.

Reset
REQ-029 reset low SHALL immediately clear all CNT, RLD, EN, AR, TO and the prescaler; timeout=0, irq=0, DATA high-Z.
REQ-030 Activity on control inputs while reset low SHALL be ignored; first tick after release SHALL occur PRESCALE clocks after first rising edge with reset high.
REQ-031 Reset asserted mid-count SHALL abort all channels without setting TO.

Verification
REQ-032 PRESCALE=1, ch0 load 3, ctrl 0b01 -> CNT 2,1,0 on next three edges; TO0 and irq rise on third; CNT holds 0.
REQ-033 ch1 load 2, ctrl 0b11 -> CNT 1, then 2 with TO1=1, then 1; ack ch1 -> TO1=0 while counting continues.
REQ-034 PRESCALE=4, ch2 load 1, EN -> TO2 rises exactly 4 clocks after enable edge aligned to prescaler; timer_out ch2 reads 0 on DATA.
REQ-035 ack ch0 on same edge ch0 goes 1->0 -> TO0=1 after edge; load ch0 0 -> TO0=1; load 5 -> TO0=0.
REQ-036 Channels 0 and 3 counting, reset pulsed low between edges -> all outputs 0 at once, no TO, counts resume only after reload and enable.

Source files
------------

// File: rtl/timer_bank.sv
// Bank of independent countdown timers sharing one prescaler, accessed through a
// bidirectional CPU bus with per-channel sticky timeout flags and a combined irq.
module timer_bank #(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 4,
    parameter  int PRESCALE = 1,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic                clk,
    input  logic                reset,
    inout  wire  [WIDTH-1:0]    DATA,
    input  logic                timer_in,
    input  logic                ctrl_in,
    input  logic                timer_out,
    input  logic                ack,
    input  logic [SEL_W-1:0]    ch_select,
    output logic [CHANNELS-1:0] timeout,
    output logic                irq,
    output logic [WIDTH-1:0]    REG_OUT_TIMER
);

    logic [PRE_W-1:0] presc_q;
    logic [PRE_W-1:0] presc_d;
    logic             tick;

    logic [SEL_W:0]      sel_ext;
    logic                sel_valid;
    logic [CHANNELS-1:0] hit_vec;
    logic [CHANNELS-1:0] to_vec;
    logic [WIDTH-1:0]    cnt_vec [CHANNELS];
    logic [WIDTH-1:0]    rd_val;
    logic                bus_drive;

    // Free-running prescaler; tick is high during the last count of each period.
    always_comb begin
        tick    = (presc_q == PRE_W'(PRESCALE - 1));
        presc_d = tick ? '0 : presc_q + PRE_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Out-of-range selects match no channel, so every access becomes a no-op.
    always_comb begin
        sel_ext   = {1'b0, ch_select};
        sel_valid = (sel_ext < (SEL_W + 1)'(CHANNELS));
        for (int i = 0; i < CHANNELS; i++) begin
            hit_vec[i] = sel_valid && (ch_select == SEL_W'(i));
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] cnt_d;
        logic [WIDTH-1:0] rld_q;
        logic [WIDTH-1:0] rld_d;
        logic             en_q;
        logic             en_d;
        logic             ar_q;
        logic             ar_d;
        logic             to_q;
        logic             to_d;
        logic             expire;

        always_comb begin
            cnt_d  = cnt_q;
            rld_d  = rld_q;
            en_d   = en_q;
            ar_d   = ar_q;
            to_d   = to_q;
            expire = tick && en_q && (cnt_q == WIDTH'(1));

            if (tick && en_q) begin
                if (cnt_q > WIDTH'(1)) begin
                    cnt_d = cnt_q - WIDTH'(1);
                end else if (expire) begin
                    cnt_d = ar_q ? rld_q : '0;
                end
            end

            // An expiry on the same edge as an ack must not be lost.
            if (expire) begin
                to_d = 1'b1;
            end else if (hit_vec[gi] && ack) begin
                to_d = 1'b0;
            end

            if (hit_vec[gi] && ctrl_in) begin
                en_d = DATA[0];
                ar_d = DATA[1];
            end

            // A load overrides whatever the tick or ack did to this channel.
            if (hit_vec[gi] && timer_in) begin
                cnt_d = DATA;
                rld_d = DATA;
                to_d  = (DATA == '0);
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q <= '0;
                rld_q <= '0;
                en_q  <= 1'b0;
                ar_q  <= 1'b0;
                to_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                rld_q <= rld_d;
                en_q  <= en_d;
                ar_q  <= ar_d;
                to_q  <= to_d;
            end
        end

        assign cnt_vec[gi] = cnt_q;
        assign to_vec[gi]  = to_q;
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (hit_vec[i]) begin
                rd_val = cnt_vec[i];
            end
        end
    end

    // The bus is released whenever the CPU may be driving it (load cycles).
    assign bus_drive     = reset && timer_out && !timer_in;
    assign DATA          = bus_drive ? rd_val : 'z;
    assign REG_OUT_TIMER = rd_val;
    assign timeout       = to_vec;
    assign irq           = |to_vec;

endmodule

// File: tb/tb_timer_bank.sv
// Directed and randomized checks of two timer_bank instances (PRESCALE 1 and 4)
// against a behavioural model of counts, reloads and sticky timeout flags.
module tb_timer_bank;
    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         timer_in;
    logic         ctrl_in;
    logic         timer_out;
    logic         ack;
    logic [1:0]   ch_select;
    logic [W-1:0] bus_val;
    logic         bus_drv;

    wire  [W-1:0] data_a;
    wire  [W-1:0] data_b;
    logic [3:0]   timeout_a;
    logic [2:0]   timeout_b;
    logic         irq_a;
    logic         irq_b;
    logic [W-1:0] reg_a;
    logic [W-1:0] reg_b;

    assign data_a = bus_drv ? bus_val : 'z;
    assign data_b = bus_drv ? bus_val : 'z;

    timer_bank #(.WIDTH(W), .CHANNELS(4), .PRESCALE(1)) u_dut_a (
        .clk(clk), .reset(reset), .DATA(data_a), .timer_in(timer_in), .ctrl_in(ctrl_in),
        .timer_out(timer_out), .ack(ack), .ch_select(ch_select), .timeout(timeout_a),
        .irq(irq_a), .REG_OUT_TIMER(reg_a)
    );

    timer_bank #(.WIDTH(W), .CHANNELS(3), .PRESCALE(4)) u_dut_b (
        .clk(clk), .reset(reset), .DATA(data_b), .timer_in(timer_in), .ctrl_in(ctrl_in),
        .timer_out(timer_out), .ack(ack), .ch_select(ch_select), .timeout(timeout_b),
        .irq(irq_b), .REG_OUT_TIMER(reg_b)
    );

    int checks   = 0;
    int failures = 0;
    int step_no  = 0;

    // Behavioural model: index 0 = instance a, 1 = instance b.
    int           nch  [2] = '{4, 3};
    int           pdiv [2] = '{1, 4};
    int           m_edges [2];
    logic [W-1:0] m_cnt [2][4];
    logic [W-1:0] m_rld [2][4];
    bit           m_en  [2][4];
    bit           m_ar  [2][4];
    bit           m_to  [2][4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_edges[i] = 0;
            for (int c = 0; c < 4; c++) begin
                m_cnt[i][c] = '0;
                m_rld[i][c] = '0;
                m_en[i][c]  = 1'b0;
                m_ar[i][c]  = 1'b0;
                m_to[i][c]  = 1'b0;
            end
        end
    endtask

    // One rising edge with reset high: a tick falls on every pdiv-th edge since release.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit tick;
            tick = ((m_edges[i] % pdiv[i]) == pdiv[i] - 1);
            m_edges[i]++;
            for (int c = 0; c < nch[i]; c++) begin
                bit sel;
                bit fired;
                sel   = (int'(ch_select) == c);
                fired = 1'b0;
                if (sel && timer_in) begin
                    m_cnt[i][c] = bus_val;
                    m_rld[i][c] = bus_val;
                    m_to[i][c]  = (bus_val == 0);
                end else begin
                    if (tick && m_en[i][c] && m_cnt[i][c] != 0) begin
                        if (m_cnt[i][c] == 1) begin
                            fired       = 1'b1;
                            m_cnt[i][c] = m_ar[i][c] ? m_rld[i][c] : '0;
                        end else begin
                            m_cnt[i][c] = m_cnt[i][c] - 1;
                        end
                    end
                    if (fired) m_to[i][c] = 1'b1;
                    else if (sel && ack) m_to[i][c] = 1'b0;
                end
                if (sel && ctrl_in) begin
                    m_en[i][c] = bus_val[0];
                    m_ar[i][c] = bus_val[1];
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            logic [3:0]   exp_to;
            logic [W-1:0] exp_rd;
            logic [W-1:0] exp_data;
            exp_to = '0;
            exp_rd = '0;
            for (int c = 0; c < nch[i]; c++) exp_to[c] = m_to[i][c];
            if (int'(ch_select) < nch[i]) exp_rd = m_cnt[i][ch_select];
            exp_data = (reset && timer_out) ? exp_rd : 'z;
            if (i == 0) begin
                chk({tag, "_to_a"}, 64'(timeout_a), 64'(exp_to));
                chk({tag, "_irq_a"}, 64'(irq_a), 64'(|exp_to));
                chk({tag, "_reg_a"}, 64'(reg_a), 64'(exp_rd));
                if (!bus_drv) chk({tag, "_data_a"}, 64'(data_a), 64'(exp_data));
            end else begin
                chk({tag, "_to_b"}, 64'(timeout_b), 64'(exp_to[2:0]));
                chk({tag, "_irq_b"}, 64'(irq_b), 64'(|exp_to));
                chk({tag, "_reg_b"}, 64'(reg_b), 64'(exp_rd));
                if (!bus_drv) chk({tag, "_data_b"}, 64'(data_b), 64'(exp_data));
            end
        end
    endtask

    task automatic drive(input logic tin, input logic cin, input logic tout, input logic ak,
                         input logic [1:0] s, input logic [W-1:0] v);
        timer_in  = tin;
        ctrl_in   = cin;
        timer_out = tout;
        ack       = ak;
        ch_select = s;
        bus_val   = v;
        bus_drv   = tin | cin;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (reset) model_edge();
        #1;
        step_no++;
        $display("step %0d %s rst=%b tin=%b cin=%b tout=%b ack=%b ch=%0d v=%h | a: cnt=%h to=%b | b: cnt=%h to=%b",
                 step_no, tag, reset, timer_in, ctrl_in, timer_out, ack, ch_select, bus_val,
                 reg_a, timeout_a, reg_b, timeout_b);
        check_all(tag);
    endtask

    task automatic pulse_reset(input string tag);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all({tag, "_now"});
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0003);
        step({tag, "_held"});
        drive(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 16'h0000);
        step({tag, "_held"});
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0);
        model_reset();
        #1;
        check_all("reset_init");
        step("reset_low");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0009);
        step("reset_low_load");
        reset = 1'b1;

        // Load 3, enable without reload: counts 2,1,0 then holds with TO set.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0003);
        step("ld_ch0");
        chk("ld_ch0_cnt", 64'(reg_a), 64'd3);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0001);
        step("en_ch0");
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, '0);
        step("cnt_2");
        chk("cnt_2", 64'(reg_a), 64'd2);
        chk("cnt_2_to", 64'(timeout_a[0]), 64'd0);
        step("cnt_1");
        chk("cnt_1", 64'(reg_a), 64'd1);
        step("cnt_0");
        chk("cnt_0", 64'(reg_a), 64'd0);
        chk("cnt_0_to", 64'(timeout_a[0]), 64'd1);
        chk("cnt_0_irq", 64'(irq_a), 64'd1);
        step("cnt_hold");
        chk("cnt_hold", 64'(reg_a), 64'd0);

        // Auto-reload channel 1 with period 2, then ack while it keeps running.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 16'h0002);
        step("ld_ch1");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 16'h0003);
        step("en_ar_ch1");
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, '0);
        step("ar_1");
        chk("ar_1", 64'(reg_a), 64'd1);
        step("ar_2");
        chk("ar_2", 64'(reg_a), 64'd2);
        chk("ar_2_to", 64'(timeout_a[1]), 64'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 2'd1, '0);
        step("ack_ch1");
        chk("ack_ch1_cnt", 64'(reg_a), 64'd1);
        chk("ack_ch1_to", 64'(timeout_a[1]), 64'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 16'h0000);
        step("dis_ch1");

        // Ack colliding with expiry, and loads of zero / nonzero.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, '0);
        step("ack_ch0");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0002);
        step("ld2_ch0");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0);
        step("ch0_1");
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, '0);
        step("ack_vs_expire");
        chk("ack_vs_expire_to", 64'(timeout_a[0]), 64'd1);
        step("ack_clear");
        chk("ack_clear_to", 64'(timeout_a[0]), 64'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
        step("ld0_ch0");
        chk("ld0_ch0_to", 64'(timeout_a[0]), 64'd1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0005);
        #1;
        chk("ld_rd_no_drive", 64'(data_a), 64'h0005);
        step("ld5_ch0");
        chk("ld5_ch0_to", 64'(timeout_a[0]), 64'd0);

        // Prescaled instance: load 1 on channel 2 and wait for the aligned tick.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 16'h0001);
        step("ld1_ch2");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 16'h0001);
        step("en_ch2");
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, '0);
        for (int k = 0; k < 6; k++) step("pre_wait");
        chk("pre_to_b2", 64'(timeout_b[2]), 64'd1);
        chk("pre_data_b", 64'(data_b), 64'd0);

        // Channel index beyond instance b's range.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 16'h0007);
        step("ld_ch3");
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, '0);
        step("rd_ch3");
        chk("oor_reg_b", 64'(reg_b), 64'd0);
        chk("oor_data_b", 64'(data_b), 64'd0);

        // Abort channels 0 and 3 mid-count with an asynchronous reset.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0009);
        step("ld9_ch0");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0001);
        step("en_ch0");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 16'h0009);
        step("ld9_ch3");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 16'h0001);
        step("en_ch3");
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, '0);
        step("run");
        pulse_reset("rst_mid");
        chk("rst_mid_to_a", 64'(timeout_a), 64'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, '0);
        for (int k = 0; k < 3; k++) step("post_rst");
        chk("post_rst_cnt0", 64'(reg_a), 64'd0);

        // Randomized traffic with small counts so expiries and reloads are frequent.
        for (int n = 0; n < 400; n++) begin
            logic         tin;
            logic         cin;
            logic         tout;
            logic         ak;
            logic [1:0]   s;
            logic [W-1:0] v;
            tin  = ($urandom_range(0, 7) == 0);
            cin  = ($urandom_range(0, 5) == 0);
            ak   = !tin && ($urandom_range(0, 4) == 0);
            tout = ($urandom_range(0, 2) == 0);
            if (cin && !tin) tout = 1'b0;
            s = 2'($urandom_range(0, 3));
            v = ($urandom_range(0, 15) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
            drive(tin, cin, tout, ak, s, v);
            step("rand");
            if (n == 200) pulse_reset("rand_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
